// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: one-hot column strobes, whole-matrix debounce, ASCII press
// events queued in a small FIFO with a sticky overflow flag.
module keypad_scan_controller #(
   parameter int SCAN_DWELL     = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [3:0] cols,
   input  logic [3:0] rows,
   input  logic       key_read,
   input  logic       clr_overflow,
   output logic       key_valid,
   output logic [7:0] key_data,
   output logic       overflow
);

   localparam int DW = $clog2(SCAN_DWELL);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {COL1, COL2, COL3, COL4} state_t;

   logic [3:0]    rows_meta_reg, rows_sync_reg;
   state_t        state_reg;
   logic [3:0]    cols_reg;
   logic [DW-1:0] dwell_reg;
   logic [1:0]    hits_reg;
   logic [7:0]    code_acc_reg;
   logic [7:0]    candidate_reg;
   logic [SW-1:0] stable_reg;
   logic [7:0]    accepted_reg;
   logic          push_reg;
   logic [7:0]    push_data_reg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          overflow_reg;

   // col: 0 = leftmost strobe (1000); pos: 0 = row bit 3
   function automatic logic [7:0] key_ascii(input logic [1:0] col, input logic [1:0] pos);
      case ({col, pos})
         4'd0:  key_ascii = 8'h31;
         4'd1:  key_ascii = 8'h34;
         4'd2:  key_ascii = 8'h37;
         4'd3:  key_ascii = 8'h2A;
         4'd4:  key_ascii = 8'h32;
         4'd5:  key_ascii = 8'h35;
         4'd6:  key_ascii = 8'h38;
         4'd7:  key_ascii = 8'h30;
         4'd8:  key_ascii = 8'h33;
         4'd9:  key_ascii = 8'h36;
         4'd10: key_ascii = 8'h39;
         4'd11: key_ascii = 8'h23;
         4'd12: key_ascii = 8'h41;
         4'd13: key_ascii = 8'h42;
         4'd14: key_ascii = 8'h43;
         4'd15: key_ascii = 8'h44;
      endcase
   endfunction

   logic          sample, scan_done;
   logic [2:0]    row_cnt, hits_total;
   logic [1:0]    row_pos, hits_sat;
   logic [7:0]    code_sum, scan_code;
   logic [7:0]    cand_next;
   logic [SW-1:0] stable_next;
   logic          accept;

   // hits_reg saturates at 2: anything beyond one asserted bit is rejected anyway
   always_comb begin
      sample    = (dwell_reg == DW'(SCAN_DWELL - 1));
      scan_done = sample && (state_reg == COL4);
      row_cnt   = '0;
      row_pos   = '0;
      for (int i = 0; i < 4; i++) begin
         if (rows_sync_reg[i]) begin
            row_cnt = row_cnt + 3'd1;
            row_pos = 2'(3 - i);
         end
      end
      hits_total = {1'b0, hits_reg} + row_cnt;
      hits_sat   = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
      code_sum   = code_acc_reg;
      if (hits_reg == 2'd0 && row_cnt == 3'd1)
         code_sum = key_ascii(state_reg, row_pos);
      scan_code = (hits_total == 3'd1) ? code_sum : 8'h00;

      if (scan_code == candidate_reg) begin
         cand_next   = candidate_reg;
         stable_next = (stable_reg == SW'(DEBOUNCE_SCANS)) ? stable_reg : stable_reg + SW'(1);
      end else begin
         cand_next   = scan_code;
         stable_next = SW'(1);
      end
      accept = (stable_next == SW'(DEBOUNCE_SCANS)) && (cand_next != accepted_reg);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rows_meta_reg <= '0;
         rows_sync_reg <= '0;
         state_reg     <= COL1;
         cols_reg      <= 4'b1000;
         dwell_reg     <= '0;
         hits_reg      <= '0;
         code_acc_reg  <= '0;
         candidate_reg <= '0;
         stable_reg    <= '0;
         accepted_reg  <= '0;
         push_reg      <= 1'b0;
         push_data_reg <= '0;
      end else begin
         rows_meta_reg <= rows;
         rows_sync_reg <= rows_meta_reg;
         push_reg      <= 1'b0;
         if (sample) begin
            dwell_reg <= '0;
            case (state_reg)
               COL1: begin state_reg <= COL2; cols_reg <= 4'b0100; end
               COL2: begin state_reg <= COL3; cols_reg <= 4'b0010; end
               COL3: begin state_reg <= COL4; cols_reg <= 4'b0001; end
               COL4: begin state_reg <= COL1; cols_reg <= 4'b1000; end
            endcase
            if (scan_done) begin
               hits_reg      <= '0;
               code_acc_reg  <= '0;
               candidate_reg <= cand_next;
               stable_reg    <= stable_next;
               if (accept) begin
                  accepted_reg  <= cand_next;
                  push_reg      <= (cand_next != 8'h00);
                  push_data_reg <= cand_next;
               end
            end else begin
               hits_reg     <= hits_sat;
               code_acc_reg <= code_sum;
            end
         end else begin
            dwell_reg <= dwell_reg + DW'(1);
         end
      end
   end

   logic full, pop, wr_en;

   always_comb begin
      full  = (count_reg == (PW+1)'(FIFO_DEPTH));
      pop   = key_read && (count_reg != '0);
      wr_en = push_reg && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= push_data_reg;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (push_reg && full && !pop)
            overflow_reg <= 1'b1;
         else if (clr_overflow)
            overflow_reg <= 1'b0;
      end
   end

   assign cols      = cols_reg;
   assign key_valid = (count_reg != '0);
   assign key_data  = (count_reg != '0) ? mem[rd_ptr_reg] : 8'h00;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a keypad model drives rows from cols, and a
// scan-level reference (history of per-scan codes, event queue) predicts the outputs.
module tb_keypad_scan_controller;
   localparam int DWELL = 4;
   localparam int DEB   = 3;
   localparam int DEPTH = 4;
   localparam int SCAN  = 4 * DWELL;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] cols;
   logic [3:0] rows;
   logic       key_read = 1'b0;
   logic       clr_overflow = 1'b0;
   logic       key_valid;
   logic [7:0] key_data;
   logic       overflow;

   logic [15:0] keys = '0;
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   byte unsigned q[$];
   byte unsigned hist[$];
   byte unsigned accepted_m = 0;
   bit ovf_m = 0;
   string keymap = "147*2580369#ABCD";

   always #5 clk = ~clk;

   keypad_scan_controller #(
      .SCAN_DWELL(DWELL),
      .DEBOUNCE_SCANS(DEB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cols(cols),
      .rows(rows),
      .key_read(key_read),
      .clr_overflow(clr_overflow),
      .key_valid(key_valid),
      .key_data(key_data),
      .overflow(overflow)
   );

   // key index = column*4 + position; column 0 is strobe 1000, position 0 is row bit 3
   always_comb begin
      rows = 4'b0000;
      for (int c = 0; c < 4; c++)
         if (cols[3-c])
            for (int p = 0; p < 4; p++)
               if (keys[c*4+p]) rows[3-p] = 1'b1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      logic [3:0] exp_cols;
      @(posedge clk);
      #1;
      cyc++;
      exp_cols = 4'b1000 >> ((cyc / DWELL) % 4);
      check("cols", {4'h0, cols}, {4'h0, exp_cols});
   endtask

   task automatic check_outputs(input string tag);
      byte unsigned head;
      head = (q.size() != 0) ? q[0] : 8'h00;
      check({tag, "_valid"}, {7'd0, key_valid}, {7'd0, q.size() != 0});
      check({tag, "_data"}, key_data, head);
      check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, ovf_m});
   endtask

   function automatic logic [15:0] km(input byte unsigned ch);
      logic [15:0] m = '0;
      for (int i = 0; i < 16; i++)
         if (keymap[i] == ch) m[i] = 1'b1;
      return m;
   endfunction

   function automatic void model_eval(input logic [15:0] mask);
      byte unsigned code = 0;
      bit same = 1;
      if ($countones(mask) == 1)
         for (int i = 0; i < 16; i++)
            if (mask[i]) code = keymap[i];
      hist.push_back(code);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
         foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
         if (same && hist[0] != accepted_m) begin
            accepted_m = hist[0];
            if (accepted_m != 0) begin
               if (q.size() < DEPTH) q.push_back(accepted_m);
               else ovf_m = 1;
            end
         end
      end
   endfunction

   function automatic void model_reset();
      q.delete();
      hist.delete();
      accepted_m = 0;
      ovf_m = 0;
   endfunction

   task automatic run_scan(input logic [15:0] mask, input bit do_pop, input bit do_clr);
      keys = mask;
      for (int t = 1; t <= SCAN; t++) begin
         tick();
         if (t == 8) begin
            check_outputs("mid");
            key_read = do_pop;
         end
         if (t == 9) begin
            key_read = 1'b0;
            if (do_pop && q.size() != 0) void'(q.pop_front());
            clr_overflow = do_clr;
         end
         if (t == 10) begin
            clr_overflow = 1'b0;
            if (do_clr) ovf_m = 0;
         end
         if (t == 12) check_outputs("post");
      end
      model_eval(mask);
      $display("[TB] scan keys=%04h pop=%0d clr=%0d queued=%0d ovf=%0d",
               mask, do_pop, do_clr, q.size(), ovf_m);
   endtask

   task automatic press(input byte unsigned ch, input int n, input int rel);
      for (int i = 0; i < n; i++) run_scan(km(ch), 0, 0);
      for (int i = 0; i < rel; i++) run_scan('0, 0, 0);
   endtask

   initial begin
      logic [15:0] m;
      int r, hold;
      bit p, c;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cols", {4'h0, cols}, 8'h08);
      check("rst_valid", {7'd0, key_valid}, 8'h00);
      check("rst_data", key_data, 8'h00);
      check("rst_ovf", {7'd0, overflow}, 8'h00);
      reset_n = 1'b1;
      cyc = 0;

      // idle scanning
      for (int i = 0; i < 3; i++) run_scan('0, 0, 0);

      // single held key: one event, popped once
      for (int i = 0; i < 10; i++) run_scan(km(8'h35), i == 5, 0);
      press(8'h00, 0, 3);

      // bounce on '9'
      press(8'h39, 2, 1);
      press(8'h39, 3, 0);
      run_scan(km(8'h39), 1, 0);
      press(8'h00, 0, 3);

      // ghost rejection, then single 'A'
      for (int i = 0; i < 5; i++) run_scan(km(8'h31) | km(8'h41), 0, 0);
      press(8'h41, 3, 0);
      run_scan(km(8'h41), 1, 0);
      press(8'h00, 0, 3);

      // fill past depth, drain in order, clear overflow
      press(8'h31, 3, 3);
      press(8'h32, 3, 3);
      press(8'h33, 3, 3);
      press(8'h34, 3, 3);
      press(8'h35, 3, 3);
      for (int i = 0; i < 5; i++) run_scan('0, 1, 0);
      run_scan('0, 0, 1);
      run_scan('0, 0, 0);

      // reset with queued entries and a key mid-debounce
      press(8'h37, 3, 3);
      press(8'h38, 3, 3);
      press(8'h2A, 2, 0);
      keys = km(8'h2A);
      for (int t = 0; t < 5; t++) tick();
      reset_n = 1'b0;
      #1;
      check("arst_valid", {7'd0, key_valid}, 8'h00);
      check("arst_ovf", {7'd0, overflow}, 8'h00);
      check("arst_cols", {4'h0, cols}, 8'h08);
      check("arst_data", key_data, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc = 0;
      model_reset();
      for (int i = 0; i < 5; i++) run_scan(km(8'h2A), 0, 0);
      press(8'h00, 0, 3);
      run_scan('0, 1, 0);
      run_scan('0, 0, 0);

      // randomized key patterns against the reference model
      for (int s = 0; s < 30; s++) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       m = '0;
            3:       m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            default: m = 16'd1 << $urandom_range(0, 15);
         endcase
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) begin
            p = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 7) == 0);
            run_scan(m, p, c);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Sequences the 4x4 matrix keypad: drives one-hot column strobes, samples rows, and debounces whole-matrix scans.
- Converts each debounced single-key press into an ASCII event and queues it in a small FIFO.
- The CPU reads events through a valid/pop interface, plus a sticky overflow flag.
- Sits between the keypad pins and the peripheral bus, replacing free-running scan/latch logic with a deterministic scheduler.

Parameters:
- SCAN_DWELL, 16, clock cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a state change; >= 1.
- FIFO_DEPTH, 4, event queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cols  out  4  one-hot column drive, active-high
- rows  in  4  raw row inputs, active-high, asynchronous to clk
- key_read  in  1  pop head of FIFO (sampled when key_valid=1)
- clr_overflow  in  1  clears overflow
- key_valid  out  1  FIFO non-empty
- key_data  out  8  ASCII of FIFO head; 0 when empty
- overflow  out  1  sticky: press event dropped because FIFO was full

Behaviour:
- Reset (async, reset_n=0): cols=4'b1000, dwell counter=0, synchronizer=0, scan accumulator=0, candidate=0, stable_cnt=0, accepted=0, FIFO empty, key_valid=0, key_data=0, overflow=0.
  - Reset mid-scan or mid-debounce discards all progress.
  - A key still held after reset is reported again after full debounce.
- Row synchronizer: rows pass through a 2-flop synchronizer before use.
- Scan FSM:
  - States are COL1..COL4, with cols = 1000, 0100, 0010, 0001 respectively.
  - Each state lasts exactly SCAN_DWELL cycles.
  - Synchronized rows are sampled on dwell count SCAN_DWELL-1; the state then advances. COL4 wraps to COL1.
  - A full scan takes 4*SCAN_DWELL cycles.
- Decode, evaluated once per scan at the COL4 sample:
  - Total asserted bits across all 16 samples = 0: code=0.
  - Exactly 1 asserted bit: code = ASCII per the key map below.
  - 2 or more asserted bits: code=0 (ghost/multi-key rejected).
- Key map (row bit 3..0 per column):
  - col 1000: '1' 0x31, '4' 0x34, '7' 0x37, '*' 0x2A
  - col 0100: '2' 0x32, '5' 0x35, '8' 0x38, '0' 0x30
  - col 0010: '3' 0x33, '6' 0x36, '9' 0x39, '#' 0x23
  - col 0001: 'A' 0x41, 'B' 0x42, 'C' 0x43, 'D' 0x44
- Debounce (on each scan evaluation):
  - If code == candidate: stable_cnt saturates-increments at DEBOUNCE_SCANS.
  - Otherwise: candidate <= code, stable_cnt <= 1.
  - When stable_cnt == DEBOUNCE_SCANS and candidate != accepted: accepted <= candidate.
  - If the new accepted value != 0, push a press event.
  - Release (accepted -> 0) pushes nothing.
  - A held key produces exactly one event.
  - A direct key-to-key change, with no release scan in between, pushes the new key.
- FIFO:
  - key_valid and key_data update the cycle after a push into an empty FIFO.
  - key_read with key_valid=1 pops; the next head appears the following cycle.
  - key_read with key_valid=0 is ignored.
  - Push when full and no pop: event dropped, overflow <= 1.
  - Push and pop in the same cycle when full: both are performed, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: clr_overflow clears it next cycle. If set and clear coincide, set wins.

Test Plan (SCAN_DWELL=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; one scan = 16 cycles):
1. Release reset, rows=0 -> cols cycles 1000, 0100, 0010, 0001, each for 4 cycles, and repeats; key_valid=0, key_data=0x00, overflow=0 throughout.
2. Assert rows=4'b0100 only while cols=0100 ('5'), held 10 scans -> exactly one event; key_valid rises after 3rd stable scan (+sync latency), key_data=0x35; key_read -> key_valid=0, no further events.
3. Bounce: '9' present 2 scans, absent 1, present 3 scans -> single event 0x39, none earlier.
4. Press '1' and 'A' together for 5 scans -> no event; then release '1' leaving 'A' for 3 scans -> single event 0x41.
5. Press/release '1','2','3','4','5' in sequence with no reads -> FIFO holds 0x31..0x34, overflow=1. Four key_read pops return 0x31, 0x32, 0x33, 0x34 in order, then key_valid=0. Pulse clr_overflow -> overflow=0.
6. Reset with two FIFO entries and a key mid-debounce -> immediately key_valid=0, overflow=0, cols=1000. Key still held -> re-reported once after 3 scans.
